dcache_sram_nway: RTL and testbench

// - Parametrised N-way set-associative data-cache storage array with true-LRU replacement.
// - Second-generation tag/data SRAM block behind the dcache controller.
// - Adds valid bits, fill-with-victim return, a registered response and an invalidate-all sweep.
// - Sits between the dcache controller FSM and the memory interface.
// - The controller issues lookup/write/fill ops and writes back the returned victim line.

---
 rtl/dcache_sram_nway.sv | 160 ++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data storage with true-LRU replacement,
// a registered response (pre-update contents) and an invalidate-all sweep.
module dcache_sram_nway #(
  parameter  int SETS   = 16,
  parameter  int WAYS   = 4,
  parameter  int TAG_W  = 23,
  parameter  int LINE_W = 256,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  input  logic              inv_all_i,
  output logic              busy_o,
  output logic              rsp_valid_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] data_o
);

  typedef enum logic [1:0] {OP_LOOKUP, OP_WRITE, OP_FILL, OP_NOP} op_e;
  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic              accept;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  sel_way;
  logic              touch_en;

  assign busy_o = (state_q == S_SWEEP);
  assign accept = req_i && !busy_o && !inv_all_i;

  // Hit detect plus victim choice: lowest invalid way beats the oldest way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_i][w] && (tag_q[idx_i][w] == tag_i)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age_q[idx_i][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_i][w]) victim = WAY_W'(w);
    end
  end

  assign sel_way  = hit ? hit_way : victim;
  assign touch_en = (op_i == OP_FILL) || (hit && ((op_i == OP_LOOKUP) || (op_i == OP_WRITE)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (inv_all_i) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status and LRU state; ops and the sweep never touch the arrays in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else if (state_q == S_SWEEP) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      for (int w = 0; w < WAYS; w++) age_q[cnt_q][w] <= WAY_W'(w);
    end else if (accept) begin
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[idx_i][w] < age_q[idx_i][sel_way]) age_q[idx_i][w] <= age_q[idx_i][w] + 1'b1;
        end
        age_q[idx_i][sel_way] <= '0;
      end
      if (op_i == OP_FILL) begin
        valid_q[idx_i][sel_way] <= 1'b1;
        dirty_q[idx_i][sel_way] <= dirty_i;
      end else if ((op_i == OP_WRITE) && hit) begin
        dirty_q[idx_i][sel_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && (op_i == OP_FILL)) begin
      tag_q[idx_i][sel_way]  <= tag_i;
      data_q[idx_i][sel_way] <= data_i;
    end else if (accept && (op_i == OP_WRITE) && hit) begin
      data_q[idx_i][sel_way] <= data_i;
    end
  end

  // Response shows the selected way as it was before this op's update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      way_o       <= '0;
      valid_o     <= 1'b0;
      dirty_o     <= 1'b0;
      tag_o       <= '0;
      data_o      <= '0;
    end else begin
      rsp_valid_o <= accept;
      if (accept) begin
        hit_o   <= hit && (op_i != OP_NOP);
        way_o   <= sel_way;
        valid_o <= valid_q[idx_i][sel_way];
        dirty_o <= dirty_q[idx_i][sel_way];
        tag_o   <= tag_q[idx_i][sel_way];
        data_o  <= data_q[idx_i][sel_way];
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Randomized scoreboard bench for dcache_sram_nway; the reference model tracks
// recency with timestamps and evicts the least recently touched way.
module tb_dcache_sram_nway;
  localparam int SETS = 16, WAYS = 4, TAG_W = 23, LINE_W = 256;
  localparam int IDX_W = 4, WAY_W = 2;

  logic              clk_i = 1'b0, rst_i = 1'b1;
  logic              req_i = 1'b0, dirty_i = 1'b0, inv_all_i = 1'b0;
  logic [1:0]        op_i = 2'd3;
  logic [IDX_W-1:0]  idx_i = '0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic [LINE_W-1:0] data_i = '0;
  logic              busy_o, rsp_valid_o, hit_o, valid_o, dirty_o;
  logic [WAY_W-1:0]  way_o;
  logic [TAG_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;

  int checks = 0, errors = 0;

  dcache_sram_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .idx_i(idx_i),
    .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i), .inv_all_i(inv_all_i),
    .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .hit_o(hit_o), .way_o(way_o),
    .valid_o(valid_o), .dirty_o(dirty_o), .tag_o(tag_o), .data_o(data_o));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic              full;
    logic              hit;
    logic [WAY_W-1:0]  way;
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t expq[$];

  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  longint            m_stamp [SETS][WAYS];
  longint            m_now = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Way 0 starts most recent, way WAYS-1 least recent.
  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_stamp[s][w] = -w;
      end
  endfunction

  function automatic exp_t model_op(input int op, input int s, input logic [TAG_W-1:0] t,
                                    input logic [LINE_W-1:0] d, input bit dty);
    exp_t e;
    int hw = -1, vic = -1, sel;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    for (int w = 0; w < WAYS && vic < 0; w++)
      if (!m_valid[s][w]) vic = w;
    if (vic < 0) begin
      vic = 0;
      for (int w = 1; w < WAYS; w++)
        if (m_stamp[s][w] < m_stamp[s][vic]) vic = w;
    end
    sel = (hw >= 0) ? hw : vic;
    e.full = (op != 3);
    e.hit = (hw >= 0) && (op != 3);
    e.way = WAY_W'(sel);
    e.valid = m_valid[s][sel];
    e.dirty = m_dirty[s][sel];
    e.tag = m_tag[s][sel];
    e.data = m_data[s][sel];
    if (op == 2) begin
      m_valid[s][sel] = 1; m_dirty[s][sel] = dty;
      m_tag[s][sel] = t; m_data[s][sel] = d;
      m_stamp[s][sel] = ++m_now;
    end else if (op == 1 && hw >= 0) begin
      m_dirty[s][sel] = 1; m_data[s][sel] = d;
      m_stamp[s][sel] = ++m_now;
    end else if (op == 0 && hw >= 0) begin
      m_stamp[s][sel] = ++m_now;
    end
    return e;
  endfunction

  task automatic applyStimulus(input int op, input int s, input logic [TAG_W-1:0] t,
                               input logic [LINE_W-1:0] d, input bit dty);
    @(negedge clk_i);
    req_i = 1'b1; op_i = 2'(op); idx_i = IDX_W'(s); tag_i = t; data_i = d; dirty_i = dty;
    if (!busy_o && !inv_all_i) expq.push_back(model_op(op, s, t, d, dty));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      req_i = 1'b0; inv_all_i = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tagname);
    chk({tagname, " busy"}, LINE_W'(busy_o), 0);
    chk({tagname, " rsp_valid"}, LINE_W'(rsp_valid_o), 0);
    chk({tagname, " hit"}, LINE_W'(hit_o), 0);
    chk({tagname, " way"}, LINE_W'(way_o), 0);
    chk({tagname, " valid"}, LINE_W'(valid_o), 0);
    chk({tagname, " dirty"}, LINE_W'(dirty_o), 0);
    chk({tagname, " tag"}, LINE_W'(tag_o), 0);
    chk({tagname, " data"}, data_o, 0);
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && rsp_valid_o) begin
        if (expq.size() == 0) begin
          chk("unexpected rsp_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("hit", LINE_W'(hit_o), LINE_W'(e.hit));
          if (e.full) begin
            chk("way", LINE_W'(way_o), LINE_W'(e.way));
            chk("valid", LINE_W'(valid_o), LINE_W'(e.valid));
            chk("dirty", LINE_W'(dirty_o), LINE_W'(e.dirty));
            if (e.valid) begin
              chk("tag", LINE_W'(tag_o), LINE_W'(e.tag));
              chk("data", data_o, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    logic [LINE_W-1:0] aa;
    aa = {(LINE_W/8){8'hAA}};
    model_clear();
    #12;
    checkOutput("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed replacement scenario on set 3.
    for (int i = 0; i < 4; i++) applyStimulus(2, 3, TAG_W'(32'h10 + i), rnd_line(), 0);
    applyStimulus(0, 3, 23'h10, '0, 0);
    applyStimulus(0, 3, 23'h10, '0, 0);
    applyStimulus(2, 3, 23'h20, rnd_line(), 0);
    applyStimulus(1, 3, 23'h12, aa, 0);
    for (int i = 0; i < 4; i++) applyStimulus(2, 3, TAG_W'(32'h40 + i), rnd_line(), 0);
    applyStimulus(1, 5, 23'h7, rnd_line(), 0);
    applyStimulus(0, 5, 23'h7, '0, 0);
    applyStimulus(3, 6, 23'h1, '0, 0);
    idle(2);

    // Random traffic over a few sets and a small tag pool to force hits and evictions.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      else applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                         TAG_W'($urandom_range(0, 6)), rnd_line(), 1'($urandom_range(0, 1)));
    end
    idle(3);

    // Invalidate-all colliding with a request; traffic during the sweep is dropped.
    @(negedge clk_i);
    req_i = 1'b1; op_i = 2'd2; idx_i = '0; tag_i = 23'h55; inv_all_i = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (!busy_o) break;
      busy_cnt++;
      req_i = 1'($urandom_range(0, 1));
      op_i = 2'($urandom_range(0, 3));
      inv_all_i = 1'($urandom_range(0, 1));
    end
    req_i = 1'b0; inv_all_i = 1'b0;
    chk("busy cycles", LINE_W'(busy_cnt), LINE_W'(SETS));
    model_clear();
    for (int s = 0; s < SETS; s++) applyStimulus(0, s, TAG_W'($urandom_range(0, 6)), '0, 0);
    idle(3);

    // Reset arriving mid-sweep, on the cycle the sweep is clearing set 7.
    applyStimulus(2, 0, 23'h9, rnd_line(), 1);
    idle(2);
    @(negedge clk_i);
    inv_all_i = 1'b1;
    @(negedge clk_i);
    inv_all_i = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk_i);
    chk("busy before reset", LINE_W'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    checkOutput("mid-sweep reset");
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(2, 0, 23'h9, rnd_line(), 0);
    applyStimulus(0, 0, 23'h9, '0, 0);
    idle(4);

    chk("scoreboard drained", LINE_W'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
